cmp_sort_ctrl: RTL

- Sequencing controller that shares one magnitude comparator (one-hot gt/eq/lt) to sort a small buffer of unsigned words.
- Words are loaded serially through a valid/ready port and sorted in place by bubble sort, one compare per cycle.
- Sorted words are streamed out through a second valid/ready port.
- Used wherever a short list needs ordering without replicating comparators.

---
 rtl/cmp_sort_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cmp_sort_ctrl.sv
// Serial-load, bubble-sort-in-place, serial-unload controller sharing one comparator.
// Define CMP_SORT_DESCEND_EN for descending order (swap on lt instead of gt).
module cmp_sort_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         done
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One-hot comparator result {gt, eq, lt}
`ifdef CMP_SORT_DESCEND_EN
  localparam logic [2:0] CMP_SWAP = 3'b001;
`else
  localparam logic [2:0] CMP_SWAP = 3'b100;
`endif

  typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

  logic [W-1:0]  mem [DEPTH];
  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] idx;
  logic [CW-1:0] lim;
  logic [CW-1:0] rd;
  logic          swapped;

  logic [W-1:0]  cmp_a;
  logic [W-1:0]  cmp_b;
  logic [2:0]    cmp;
  logic          load_acc;
  logic          swap;
  logic          pass_end;
  logic          any_swap;

  assign in_ready = (state == LOAD) && (count < CW'(DEPTH));
  assign busy     = (state != LOAD);
  assign load_acc = in_valid && in_ready;

  // Shared comparator on the adjacent pair selected by idx
  assign cmp_a    = mem[AW'(idx)];
  assign cmp_b    = mem[AW'(idx + CW'(1))];
  assign cmp      = {cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};
  assign swap     = (state == SORT) && (lim != '0) && (cmp == CMP_SWAP);
  assign pass_end = (idx == lim - CW'(1));
  assign any_swap = swapped || swap;

  // Buffer storage: serial load or in-place swap; never cleared by reset
  always_ff @(posedge clk) begin
    if (load_acc) begin
      mem[AW'(count)] <= in_data;
    end else if (swap) begin
      mem[AW'(idx)]           <= cmp_b;
      mem[AW'(idx + CW'(1))]  <= cmp_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      count     <= '0;
      idx       <= '0;
      lim       <= '0;
      rd        <= '0;
      swapped   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        LOAD: begin
          if (load_acc) count <= count + CW'(1);
          // A word accepted alongside start is part of the sort
          if (start && (count != '0 || load_acc)) begin
            state   <= SORT;
            lim     <= count + CW'(load_acc) - CW'(1);
            idx     <= '0;
            rd      <= '0;
            swapped <= 1'b0;
          end
        end
        SORT: begin
          if (lim == '0) begin
            state     <= UNLOAD;
            out_valid <= 1'b1;
            out_data  <= mem[0];
          end else if (pass_end) begin
            if (!any_swap || lim == CW'(1)) begin
              state     <= UNLOAD;
              out_valid <= 1'b1;
              // mem[0] may be rewritten by this very compare
              out_data  <= (swap && idx == '0) ? cmp_b : mem[0];
            end else begin
              lim     <= lim - CW'(1);
              idx     <= '0;
              swapped <= 1'b0;
            end
          end else begin
            idx     <= idx + CW'(1);
            swapped <= any_swap;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (rd == count - CW'(1)) begin
              state     <= LOAD;
              count     <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              rd       <= rd + CW'(1);
              out_data <= mem[AW'(rd + CW'(1))];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
